// File: rtl/wishbone_slave_adapter.sv
// rtl/wishbone_slave_adapter.sv - Wishbone B4 classic-cycle slave bridged to a req/valid local slave
// All outputs registered; a watchdog terminates requests the local slave never answers.
module wishbone_slave_adapter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TAGSIZE        = 2,
  parameter int TIMEOUT        = 16,
  parameter int RTY_ON_TIMEOUT = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                    wb_we_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic [TAGSIZE-1:0]      wb_tga_i,
  input  logic [TAGSIZE-1:0]      wb_tgc_i,
  input  logic [TAGSIZE-1:0]      wb_tgd_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [TAGSIZE-1:0]      wb_tgd_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_rty_o,
  output logic                    req_o,
  output logic [ADDR_WIDTH-1:0]   addr_o,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic [DATA_WIDTH/8-1:0] sel_o,
  output logic                    we_o,
  input  logic [DATA_WIDTH-1:0]   data_i,
  input  logic                    valid_i,
  input  logic                    err_i
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t                  state, state_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic                    req_n, we_n, ack_n, err_n, rty_n;
  logic [ADDR_WIDTH-1:0]   addr_n;
  logic [DATA_WIDTH-1:0]   data_n, dat_n;
  logic [SEL_W-1:0]        sel_n;
  logic [TAGSIZE-1:0]      tgd_n;

  // Cycle and data tags are accepted on the bus but carry no meaning here.
  logic unused_tags;
  assign unused_tags = ^{wb_tgc_i, wb_tgd_i};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cnt      <= '0;
      req_o    <= 1'b0;
      addr_o   <= '0;
      data_o   <= '0;
      sel_o    <= '0;
      we_o     <= 1'b0;
      wb_dat_o <= '0;
      wb_tgd_o <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_rty_o <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      req_o    <= req_n;
      addr_o   <= addr_n;
      data_o   <= data_n;
      sel_o    <= sel_n;
      we_o     <= we_n;
      wb_dat_o <= dat_n;
      wb_tgd_o <= tgd_n;
      wb_ack_o <= ack_n;
      wb_err_o <= err_n;
      wb_rty_o <= rty_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    req_n   = req_o;
    addr_n  = addr_o;
    data_n  = data_o;
    sel_n   = sel_o;
    we_n    = we_o;
    dat_n   = wb_dat_o;
    tgd_n   = wb_tgd_o;
    ack_n   = 1'b0;
    err_n   = 1'b0;
    rty_n   = 1'b0;

    case (state)
      IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          addr_n  = wb_adr_i;
          data_n  = wb_dat_i;
          sel_n   = wb_sel_i;
          we_n    = wb_we_i;
          tgd_n   = wb_tga_i;
          req_n   = 1'b1;
          cnt_n   = '0;
          state_n = REQ;
        end
      end

      REQ: begin
        cnt_n = cnt + 1'b1;
        // Abort beats any local response; err beats valid; valid beats the watchdog.
        if (!wb_cyc_i) begin
          req_n   = 1'b0;
          state_n = IDLE;
        end else if (err_i) begin
          req_n   = 1'b0;
          err_n   = 1'b1;
          state_n = RESP;
        end else if (valid_i) begin
          req_n   = 1'b0;
          ack_n   = 1'b1;
          if (!we_o) begin
            dat_n = data_i;
          end
          state_n = RESP;
        end else if ((TIMEOUT != 0) && (cnt == CNT_LAST)) begin
          req_n = 1'b0;
          if (RTY_ON_TIMEOUT != 0) begin
            rty_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          state_n = RESP;
        end
      end

      // Terminations drop here; the bus is not sampled so a held stb is not re-latched.
      RESP: begin
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_wishbone_slave_adapter.sv
// tb/tb_wishbone_slave_adapter.sv - directed table-driven bench for wishbone_slave_adapter
// A long-timeout instance carries the main tests; two TIMEOUT=4 instances cover err/rty watchdog.
module tb_wishbone_slave_adapter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] wb_adr_i, wb_dat_i, data_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i, valid_i, err_i;
  logic [1:0]  wb_tga_i, wb_tgc_i, wb_tgd_i;

  logic [31:0] wb_dat_o, addr_o, data_o;
  logic [3:0]  sel_o;
  logic [1:0]  wb_tgd_o;
  logic        wb_ack_o, wb_err_o, wb_rty_o, req_o, we_o;

  logic [31:0] e_dat_o, e_addr_o, e_data_o;
  logic [3:0]  e_sel_o;
  logic [1:0]  e_tgd_o;
  logic        e_ack_o, e_err_o, e_rty_o, e_req_o, e_we_o;

  logic [31:0] r_dat_o, r_addr_o, r_data_o;
  logic [3:0]  r_sel_o;
  logic [1:0]  r_tgd_o;
  logic        r_ack_o, r_err_o, r_rty_o, r_req_o, r_we_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  wishbone_slave_adapter #(.TIMEOUT(16), .RTY_ON_TIMEOUT(0)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_tga_i(wb_tga_i),
    .wb_tgc_i(wb_tgc_i), .wb_tgd_i(wb_tgd_i), .wb_dat_o(wb_dat_o), .wb_tgd_o(wb_tgd_o),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o), .req_o(req_o),
    .addr_o(addr_o), .data_o(data_o), .sel_o(sel_o), .we_o(we_o), .data_i(data_i),
    .valid_i(valid_i), .err_i(err_i));

  wishbone_slave_adapter #(.TIMEOUT(4), .RTY_ON_TIMEOUT(0)) u_to_err (
    .clk_i(clk_i), .rst_i(rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_tga_i(wb_tga_i),
    .wb_tgc_i(wb_tgc_i), .wb_tgd_i(wb_tgd_i), .wb_dat_o(e_dat_o), .wb_tgd_o(e_tgd_o),
    .wb_ack_o(e_ack_o), .wb_err_o(e_err_o), .wb_rty_o(e_rty_o), .req_o(e_req_o),
    .addr_o(e_addr_o), .data_o(e_data_o), .sel_o(e_sel_o), .we_o(e_we_o), .data_i(data_i),
    .valid_i(valid_i), .err_i(err_i));

  wishbone_slave_adapter #(.TIMEOUT(4), .RTY_ON_TIMEOUT(1)) u_to_rty (
    .clk_i(clk_i), .rst_i(rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_tga_i(wb_tga_i),
    .wb_tgc_i(wb_tgc_i), .wb_tgd_i(wb_tgd_i), .wb_dat_o(r_dat_o), .wb_tgd_o(r_tgd_o),
    .wb_ack_o(r_ack_o), .wb_err_o(r_err_o), .wb_rty_o(r_rty_o), .req_o(r_req_o),
    .addr_o(r_addr_o), .data_o(r_data_o), .sel_o(r_sel_o), .we_o(r_we_o), .data_i(data_i),
    .valid_i(valid_i), .err_i(err_i));

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [1:0]  tga;
    int          wait_cyc;
    logic [31:0] rdata;
    logic        valid;
    logic        err;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_dat;
    logic [1:0]  exp_tgd;
  } vec_t;

  vec_t vecs[6];
  vec_t v_after_abort;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = v.we; wb_adr_i = v.adr; wb_dat_i = v.dat;
    wb_sel_i = v.sel; wb_tga_i = v.tga; data_i = v.rdata; valid_i = 1'b0; err_i = 1'b0;
    tick();
    chk({v.name, ".req_rise"}, {31'd0, req_o}, 32'd1);
    chk({v.name, ".addr_o"}, addr_o, v.adr);
    chk({v.name, ".data_o"}, data_o, v.dat);
    chk({v.name, ".sel_o_we_o"}, {27'd0, sel_o, we_o}, {27'd0, v.sel, v.we});
    for (int i = 0; i < v.wait_cyc; i++) begin
      tick();
      chk({v.name, ".req_hold"}, {29'd0, req_o, addr_o == v.adr, wb_ack_o | wb_err_o | wb_rty_o},
          {29'd0, 1'b1, 1'b1, 1'b0});
    end
    valid_i = v.valid; err_i = v.err;
    tick();
    valid_i = 1'b0; err_i = 1'b0;
    chk({v.name, ".term_ack_err_rty_req"}, {28'd0, wb_ack_o, wb_err_o, wb_rty_o, req_o},
        {28'd0, v.exp_ack, v.exp_err, 1'b0, 1'b0});
    chk({v.name, ".wb_dat_o"}, wb_dat_o, v.exp_dat);
    chk({v.name, ".wb_tgd_o"}, {30'd0, wb_tgd_o}, {30'd0, v.exp_tgd});
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick();
    chk({v.name, ".term_one_cycle"}, {29'd0, wb_ack_o, wb_err_o, wb_rty_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench watchdog");
  end

  initial begin
    rst_i = 1'b1; wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_tga_i = '0; wb_tgc_i = 2'd3; wb_tgd_i = 2'd1;
    data_i = '0; valid_i = 1'b0; err_i = 1'b0;

    //          name               we    adr            dat            sel   tga  w   rdata          v     e     ack   err   exp_dat        tgd
    vecs[0] = '{"wr_basic",        1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2'd1, 1, 32'h1111_1111, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 2'd1};
    vecs[1] = '{"rd_wait5",        1'b0, 32'h0000_0020, 32'h0000_0000, 4'hF, 2'd2, 5, 32'hCAFE_0001, 1'b1, 1'b0, 1'b1, 1'b0, 32'hCAFE_0001, 2'd2};
    vecs[2] = '{"rd_err_and_valid",1'b0, 32'h0000_0024, 32'h0000_0000, 4'hF, 2'd3, 0, 32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b1, 32'hCAFE_0001, 2'd3};
    vecs[3] = '{"rd_fast",         1'b0, 32'h0000_0028, 32'h0000_0000, 4'hF, 2'd0, 2, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b1, 1'b0, 32'hA5A5_A5A5, 2'd0};
    vecs[4] = '{"wr_err",          1'b1, 32'h0000_002C, 32'hFFFF_0000, 4'h3, 2'd1, 0, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA5A5_A5A5, 2'd1};
    vecs[5] = '{"rd_valid_at_tmo", 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4'hF, 2'd2, 15,32'h0BAD_F00D, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0BAD_F00D, 2'd2};
    v_after_abort = '{"after_abort",   1'b0, 32'h0000_0034, 32'h0000_0000, 4'hF, 2'd1, 0, 32'h600D_CAFE, 1'b1, 1'b0, 1'b1, 1'b0, 32'h600D_CAFE, 2'd1};

    #1;
    chk("reset.ctrl", {27'd0, req_o, wb_ack_o, wb_err_o, wb_rty_o, we_o}, 32'd0);
    chk("reset.dat", wb_dat_o | addr_o | data_o | {28'd0, sel_o} | {30'd0, wb_tgd_o}, 32'd0);
    tick(); tick();
    rst_i = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // abort: cyc dropped in the second REQ cycle alongside a valid that must be ignored
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h30; wb_tga_i = 2'd1;
    data_i = 32'hDEAD_0000;
    tick();
    chk("abort.req_rise", {31'd0, req_o}, 32'd1);
    tick();
    chk("abort.req_hold", {31'd0, req_o}, 32'd1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; valid_i = 1'b1;
    tick();
    valid_i = 1'b0;
    chk("abort.req_fall_no_term", {28'd0, req_o, wb_ack_o, wb_err_o, wb_rty_o}, 32'd0);
    tick();
    chk("abort.still_quiet", {28'd0, req_o, wb_ack_o, wb_err_o, wb_rty_o}, 32'd0);
    chk("abort.dat_kept", wb_dat_o, 32'h0BAD_F00D);
    run_vec(v_after_abort);

    // watchdog: TIMEOUT=4, no local response
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h50; wb_tga_i = 2'd0;
    tick();
    chk("tmo.req_rise", {30'd0, e_req_o, r_req_o}, 32'd3);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("tmo.req_hold", {26'd0, e_req_o, r_req_o, e_err_o, e_rty_o, r_err_o, r_rty_o},
          {26'd0, 6'b110000});
    end
    tick();
    chk("tmo.err_variant", {29'd0, e_req_o, e_err_o, e_rty_o | e_ack_o}, {29'd0, 3'b010});
    chk("tmo.rty_variant", {29'd0, r_req_o, r_rty_o, r_err_o | r_ack_o}, {29'd0, 3'b010});
    tick();
    chk("tmo.one_cycle", {28'd0, e_err_o, e_rty_o, r_err_o, r_rty_o}, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick(); tick();

    // four back-to-back reads with cyc held and valid always high: ack every 3 cycles
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; valid_i = 1'b1;
    for (int b = 0; b < 4; b++) begin
      wb_adr_i = 32'h100 + 32'(4 * b);
      data_i   = 32'hB0B0_0000 + 32'(b);
      tick();
      chk("burst.req", {30'd0, req_o, wb_ack_o}, {30'd0, 2'b10});
      chk("burst.addr_o", addr_o, 32'h100 + 32'(4 * b));
      tick();
      chk("burst.ack", {30'd0, req_o, wb_ack_o}, {30'd0, 2'b01});
      chk("burst.dat", wb_dat_o, 32'hB0B0_0000 + 32'(b));
      tick();
      chk("burst.resp_no_relatch", {30'd0, req_o, wb_ack_o}, 32'd0);
    end
    valid_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick();

    // asynchronous reset in the middle of a write beat
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'h40;
    wb_dat_i = 32'h1234_5678; wb_tga_i = 2'd3;
    tick();
    chk("rst.req_before", {31'd0, req_o}, 32'd1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("rst.ctrl_async", {27'd0, req_o, wb_ack_o, wb_err_o, wb_rty_o, we_o}, 32'd0);
    chk("rst.data_async", wb_dat_o | addr_o | data_o | {30'd0, wb_tgd_o}, 32'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();
    run_vec(vecs[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
